// File: rtl/uart_rx_oversampled_if.sv
// Receiver-side bundle: serial line and baud tick in, parallel word and status out.
`timescale 1ns/1ps
interface uart_rx_oversampled_if #(
  parameter int DBIT = 8
);
  logic            rx;
  logic            s_tick;
  logic [DBIT-1:0] rx_dout;
  logic            rx_done_tick;
  logic            frame_err;

  modport master (
    output rx,
    output s_tick,
    input  rx_dout,
    input  rx_done_tick,
    input  frame_err
  );

  modport slave (
    input  rx,
    input  s_tick,
    output rx_dout,
    output rx_done_tick,
    output frame_err
  );
endinterface

// File: rtl/uart_rx_oversampled.sv
// 16x-oversampled UART receiver: start/DBIT data (LSB first)/stop framing,
// framing-error flag, and a break state that swallows a held-low line.
`timescale 1ns/1ps
module uart_rx_oversampled #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16
) (
  input logic                  clk,
  input logic                  reset_n,
  uart_rx_oversampled_if.slave bus
);
  localparam int SW = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NW = $clog2(DBIT);
  localparam logic [SW-1:0] MID_START = SW'(7);
  localparam logic [SW-1:0] LAST_DATA = SW'(15);
  localparam logic [SW-1:0] LAST_STOP = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] LAST_BIT  = NW'(DBIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BRK   = 3'd4
  } state_t;

  state_t          state_r, state_s;
  logic [SW-1:0]   s_cnt_r, s_cnt_s;
  logic [NW-1:0]   n_cnt_r, n_cnt_s;
  logic [DBIT-1:0] shift_r, shift_s;
  logic [DBIT-1:0] dout_r, dout_s;
  logic            done_r, done_s;
  logic            ferr_r, ferr_s;
  logic            sync1_r, sync2_r;
  logic            rx_s;

  // Two-flop synchronizer for the asynchronous line; resets to idle-high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_r <= 1'b1;
      sync2_r <= 1'b1;
    end else begin
      sync1_r <= bus.rx;
      sync2_r <= sync1_r;
    end
  end

  assign rx_s = sync2_r;

  // FSM, counters, shift register and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      s_cnt_r <= {SW{1'b0}};
      n_cnt_r <= {NW{1'b0}};
      shift_r <= {DBIT{1'b0}};
      dout_r  <= {DBIT{1'b0}};
      done_r  <= 1'b0;
      ferr_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      s_cnt_r <= s_cnt_s;
      n_cnt_r <= n_cnt_s;
      shift_r <= shift_s;
      dout_r  <= dout_s;
      done_r  <= done_s;
      ferr_r  <= ferr_s;
    end
  end

  // Next-state logic; counting only happens on s_tick cycles.
  always_comb begin
    state_s = state_r;
    s_cnt_s = s_cnt_r;
    n_cnt_s = n_cnt_r;
    shift_s = shift_r;
    dout_s  = dout_r;
    ferr_s  = ferr_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!rx_s) begin
          state_s = ST_START;
          s_cnt_s = {SW{1'b0}};
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bus.s_tick && (s_cnt_r == MID_START)) begin
          // A start bit that is high again at mid-bit was only a glitch.
          if (!rx_s) begin
            state_s = ST_DATA;
            s_cnt_s = {SW{1'b0}};
            n_cnt_s = {NW{1'b0}};
          end else begin
            state_s = ST_IDLE;
          end
        end else if (bus.s_tick) begin
          s_cnt_s = s_cnt_r + SW'(1);
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      ST_DATA: begin
        if (bus.s_tick && (s_cnt_r == LAST_DATA)) begin
          s_cnt_s = {SW{1'b0}};
          shift_s = {rx_s, shift_r[DBIT-1:1]};
          if (n_cnt_r == LAST_BIT) begin
            state_s = ST_STOP;
          end else begin
            n_cnt_s = n_cnt_r + NW'(1);
          end
        end else if (bus.s_tick) begin
          s_cnt_s = s_cnt_r + SW'(1);
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      ST_STOP: begin
        if (bus.s_tick && (s_cnt_r == LAST_STOP)) begin
          dout_s  = shift_r;
          ferr_s  = ~rx_s;
          done_s  = 1'b1;
          state_s = rx_s ? ST_IDLE : ST_BRK;
        end else if (bus.s_tick) begin
          s_cnt_s = s_cnt_r + SW'(1);
        end else begin
          s_cnt_s = s_cnt_r;
        end
      end
      ST_BRK: begin
        if (rx_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_BRK;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  assign bus.rx_dout      = dout_r;
  assign bus.rx_done_tick = done_r;
  assign bus.frame_err    = ferr_r;
endmodule
